// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch front end: owns the fetch PC, issues word reads over req/gnt/rvalid,
// buffers in-order responses in a small prefetch queue and hands {instr, instr_pc} to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned   PTR_W   = $clog2(DEPTH);
  localparam int unsigned   CNT_W   = PTR_W + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      q_pc_q    [DEPTH];
  logic [31:0]      q_pc_d    [DEPTH];
  logic [31:0]      q_instr_q [DEPTH];
  logic [31:0]      q_instr_d [DEPTH];

  logic             grant;
  logic             pop;
  logic             push;
  logic             queue_nonempty;
  logic [31:0]      target_pc;
  logic [CNT_W:0]   occupancy;

  // Outstanding plus buffered words never exceed DEPTH, so a response always has a free slot.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
  assign target_pc      = {redirect_pc[31:2], 2'b00};
  assign queue_nonempty = (count_q != '0);

  assign imem_req    = !rst && !redirect && (occupancy < CREDITS);
  assign imem_addr   = rst ? RESET_PC : fetch_pc_q;
  assign instr_valid = !rst && queue_nonempty;
  assign instr       = instr_valid ? q_instr_q[rd_ptr_q] : NOP;
  assign instr_pc    = rst ? RESET_PC : (queue_nonempty ? q_pc_q[rd_ptr_q] : last_pc_q);

  assign grant = imem_req && imem_gnt;
  assign pop   = instr_valid && instr_ready && !redirect;
  assign push  = imem_rvalid && !redirect && (discard_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    inflight_d = inflight_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    q_pc_d     = q_pc_q;
    q_instr_d  = q_instr_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      // Everything still in flight belongs to the old path; a response landing now is dropped too.
      discard_d  = inflight_q - CNT_W'(imem_rvalid);
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      last_pc_d  = target_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push) begin
        q_pc_d[wr_ptr_q]    = resp_pc_q;
        q_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        resp_pc_d           = resp_pc_q + 32'd4;
      end
      if (pop) begin
        last_pc_d = q_pc_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      q_pc_q     <= '{default: '0};
      q_instr_q  <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      q_pc_q     <= q_pc_d;
      q_instr_q  <= q_instr_d;
    end
  end

  // Memory protocol violations are only flagged; the unit does not try to recover.
  a_rvalid_outstanding : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (inflight_q != '0));
  a_gnt_needs_req : assert property (@(posedge clk) disable iff (rst)
    imem_gnt |-> imem_req);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit with a queue-based reference model
// and a small in-order memory responder with variable latency.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        gnt_en;

  assign imem_gnt = imem_req & gnt_en;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  // Second instance: wrapping reset PC, deeper queue, gnt tied to req, 1-cycle memory, ready high.
  logic        w_req, w_valid;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [31:0] w_rdata = 32'h0;

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_req),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc), .instr_ready(1'b1)
  );

  always @(posedge clk) begin
    w_rvalid <= !rst && w_req;
    w_rdata  <= w_addr ^ XMASK;
  end

  typedef struct { logic [31:0] pc; logic [31:0] ins; } entry_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  entry_t      m_q[$];
  mreq_t       mem_q[$];
  logic [31:0] popped[$];
  logic [31:0] m_fetch, m_resp, m_last;
  int          m_inflight, m_discard;
  int          cyc, last_due, mem_lat;
  int          n_cmp, n_err;

  logic        s_req, s_valid, s_rvalid, s_w_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_w_addr, s_w_pc, s_w_instr;

  logic [31:0] wrap_addr [6] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
                                 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
  logic [31:0] wrap_pc   [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    mem_q.delete();
    m_fetch    = 32'h0;
    m_resp     = 32'h0;
    m_last     = 32'h0;
    m_inflight = 0;
    m_discard  = 0;
    last_due   = -1;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
  task automatic run_cycle(input bit rst_i, input bit redir_i, input logic [31:0] rpc_i,
                           input bit rdy_i, input bit gnt_i);
    bit          e_req, e_valid, rv;
    logic [31:0] e_addr, e_instr, e_pc, rd, tgt;
    int          d;
    rst         = rst_i;
    redirect    = redir_i;
    redirect_pc = rpc_i;
    instr_ready = rdy_i;
    gnt_en      = gnt_i;
    rv = !rst_i && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rd = rv ? (mem_q[0].addr ^ XMASK) : $urandom;
    imem_rvalid = rv;
    imem_rdata  = rd;

    if (rst_i) begin
      e_req = 1'b0; e_addr = 32'h0; e_valid = 1'b0; e_instr = NOP; e_pc = 32'h0;
    end else begin
      e_req   = !redir_i && (m_inflight + m_q.size() < DEPTH);
      e_addr  = m_fetch;
      e_valid = (m_q.size() > 0);
      e_instr = NOP;
      e_pc    = m_last;
      if (e_valid) begin
        e_instr = m_q[0].ins;
        e_pc    = m_q[0].pc;
      end
    end

    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_instr = instr;
    s_pc = instr_pc; s_rvalid = imem_rvalid;
    s_w_addr = w_addr; s_w_valid = w_valid; s_w_pc = w_pc; s_w_instr = w_instr;
    chk("imem_req", s_req, e_req);
    chk("imem_addr", s_addr, e_addr);
    chk("instr_valid", s_valid, e_valid);
    chk("instr", s_instr, e_instr);
    chk("instr_pc", s_pc, e_pc);
    if (!rst_i && !redir_i && rdy_i && s_valid) popped.push_back(s_pc);

    @(posedge clk);
    if (rst_i) begin
      model_reset();
    end else begin
      tgt = {rpc_i[31:2], 2'b00};
      if (rv) m_inflight--;
      if (redir_i) begin
        m_q.delete();
        m_discard = m_inflight;
        m_fetch   = tgt;
        m_resp    = tgt;
        m_last    = tgt;
      end else begin
        if (e_valid && rdy_i) begin
          m_last = m_q[0].pc;
          void'(m_q.pop_front());
        end
        if (rv) begin
          if (m_discard > 0) m_discard--;
          else begin
            m_q.push_back('{pc: m_resp, ins: rd});
            m_resp += 32'd4;
          end
        end
        if (e_req && gnt_i) begin
          m_fetch += 32'd4;
          m_inflight++;
        end
      end
      if (rv) void'(mem_q.pop_front());
      if (s_req && gnt_i) begin
        d = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_q.push_back('{addr: s_addr, due: d});
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  grants;
    bit  seen;
    n_cmp = 0; n_err = 0; cyc = 0; mem_lat = 1;
    model_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0; gnt_en = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(posedge clk); #1;

    // Reset, then streaming; wrap instance checked on the same cycles.
    repeat (3) run_cycle(1, 0, 32'h0, 1, 1);
    chk("rst_imem_req", s_req, 1'b0);
    chk("rst_instr_valid", s_valid, 1'b0);
    for (int k = 0; k < 12; k++) begin
      run_cycle(0, 0, 32'h0, 1, 1);
      if (k == 0) begin
        chk("post_rst_valid", s_valid, 1'b0);
        chk("post_rst_instr", s_instr, NOP);
        chk("post_rst_pc", s_pc, 32'h0);
        chk("post_rst_addr", s_addr, 32'h0);
      end
      if (k == 2) begin
        chk("stream_first_valid", s_valid, 1'b1);
        chk("stream_first_pc", s_pc, 32'h0);
        chk("stream_first_instr", s_instr, 32'hA5A5_0000);
      end
      if (k == 3) chk("stream_second_pc", s_pc, 32'h4);
      if (k < 6) chk("wrap_addr", s_w_addr, wrap_addr[k]);
      if (k >= 2 && k < 6) begin
        chk("wrap_valid", s_w_valid, 1'b1);
        chk("wrap_pc", s_w_pc, wrap_pc[k-2]);
        chk("wrap_instr", s_w_instr, wrap_pc[k-2] ^ XMASK);
      end
    end

    // Backpressure: decode stalled for 10 cycles.
    repeat (2) run_cycle(1, 0, 32'h0, 1, 1);
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(0, 0, 32'h0, 0, 1);
      if (s_req) grants++;
    end
    chk("bp_grants", grants, 2);
    chk("bp_req_stopped", s_req, 1'b0);
    chk("bp_head_pc", s_pc, 32'h0);
    popped.delete();
    for (int k = 0; k < 20 && popped.size() < 3; k++) run_cycle(0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 3; i++)
      chk("bp_pop_order", (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Redirect with two requests in flight, 3-cycle memory.
    repeat (2) run_cycle(1, 0, 32'h0, 1, 1);
    mem_lat = 3;
    run_cycle(0, 0, 32'h0, 1, 1);
    run_cycle(0, 0, 32'h0, 1, 1);
    run_cycle(0, 1, 32'h0000_0200, 1, 1);
    run_cycle(0, 0, 32'h0, 1, 1);
    chk("rd_next_addr", s_addr, 32'h0000_0200);
    chk("rd_empty_pc", s_pc, 32'h0000_0200);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      run_cycle(0, 0, 32'h0, 1, 1);
      if (s_valid) begin
        seen = 1'b1;
        chk("rd_first_pc", s_pc, 32'h0000_0200);
        chk("rd_first_instr", s_instr, 32'hA5A5_0200);
      end
    end
    chk("rd_first_seen", seen, 1'b1);

    // Misaligned redirect coinciding with a response and a ready head.
    repeat (2) run_cycle(1, 0, 32'h0, 1, 1);
    mem_lat = 1;
    for (int k = 0; k < 20 && !((mem_q.size() > 0) && (mem_q[0].due <= cyc) && (m_q.size() > 0)); k++)
      run_cycle(0, 0, 32'h0, 1, 1);
    run_cycle(0, 1, 32'h0000_0103, 1, 1);
    chk("mis_rvalid_present", s_rvalid, 1'b1);
    chk("mis_head_valid", s_valid, 1'b1);
    run_cycle(0, 0, 32'h0, 1, 1);
    chk("mis_addr", s_addr, 32'h0000_0100);
    chk("mis_valid", s_valid, 1'b0);
    chk("mis_pc", s_pc, 32'h0000_0100);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      run_cycle(0, 0, 32'h0, 1, 1);
      if (s_valid) begin
        seen = 1'b1;
        chk("mis_first_pc", s_pc, 32'h0000_0100);
        chk("mis_first_instr", s_instr, 32'hA5A5_0100);
      end
    end
    chk("mis_first_seen", seen, 1'b1);

    // Reset mid-stream with a buffered word and one in flight.
    repeat (2) run_cycle(1, 0, 32'h0, 1, 1);
    mem_lat = 3;
    for (int k = 0; k < 20 && !((m_q.size() == 1) && (m_inflight == 1)); k++)
      run_cycle(0, 0, 32'h0, 0, 1);
    run_cycle(1, 0, 32'h0, 1, 1);
    run_cycle(0, 0, 32'h0, 1, 1);
    chk("mrst_valid", s_valid, 1'b0);
    chk("mrst_instr", s_instr, NOP);
    chk("mrst_addr", s_addr, 32'h0);
    chk("mrst_pc", s_pc, 32'h0);
    mem_lat = 1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      run_cycle(0, 0, 32'h0, 1, 1);
      if (s_valid) begin
        seen = 1'b1;
        chk("mrst_restart_pc", s_pc, 32'h0);
      end
    end
    chk("mrst_restart_seen", seen, 1'b1);

    // Back-to-back redirects: the last target wins.
    run_cycle(0, 1, 32'h0000_1000, 1, 1);
    run_cycle(0, 1, 32'h0000_2002, 1, 1);
    run_cycle(0, 0, 32'h0, 1, 1);
    chk("b2b_addr", s_addr, 32'h0000_2000);

    // Randomised traffic.
    mem_lat = 0;
    for (int k = 0; k < 3000; k++) begin
      bit r_rst, r_redir;
      r_rst   = ($urandom_range(0, 199) == 0);
      r_redir = ($urandom_range(0, 15) == 0);
      run_cycle(r_rst, r_redir, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
